// File: rtl/spi_ctrl_rx.sv
// SPI mode-0 write-only control port: synchronizes sck/sdi/ss_n into clk,
// assembles address + burst data bytes and issues one-clk register writes.
module spi_ctrl_rx #(
  parameter logic [7:0] CTRL_ADRS = 8'h00,
  parameter logic [7:0] DATA_ADRS = 8'h01
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sck,
  input  logic       sdi,
  input  logic       ss_n,
  output logic [7:0] synth_ctrl,
  output logic [7:0] synth_data,
  output logic [7:0] reg_adrs,
  output logic [7:0] reg_data,
  output logic       reg_wr,
  output logic       frame_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;

  typedef struct packed {
    logic [7:0] adrs;
    logic [7:0] data;
  } wr_t;

  logic [2:0] sck_pipe;
  logic [2:0] ss_pipe;
  logic [1:0] sdi_pipe;
  logic [1:0] flush_cnt;
  logic       flush_done;

  logic       sck_p;
  logic       ss_fall_p;
  logic       ss_rise_p;
  logic       bit_q;

  logic [1:0] state;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic [7:0] ptr;
  logic       data_seen;

  logic [7:0] byte_nxt;
  logic       byte_done;
  logic       partial;
  wr_t        wr_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sck_pipe <= '0;
      ss_pipe  <= '1;
      sdi_pipe <= '0;
    end else begin
      sck_pipe <= {sck_pipe[1:0], sck};
      ss_pipe  <= {ss_pipe[1:0], ss_n};
      sdi_pipe <= {sdi_pipe[0], sdi};
    end
  end

  // Edges are masked until the pipes have flushed their reset values, so a
  // frame already in progress at reset release is not mistaken for a new one.
  assign flush_done = &flush_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flush_cnt <= '0;
      sck_p     <= 1'b0;
      ss_fall_p <= 1'b0;
      ss_rise_p <= 1'b0;
      bit_q     <= 1'b0;
    end else begin
      if (!flush_done) flush_cnt <= flush_cnt + 2'd1;
      sck_p     <= flush_done & sck_pipe[1] & ~sck_pipe[2];
      ss_fall_p <= flush_done & ss_pipe[2] & ~ss_pipe[1];
      ss_rise_p <= flush_done & ~ss_pipe[2] & ss_pipe[1];
      bit_q     <= sdi_pipe[1];
    end
  end

  assign byte_nxt  = {shreg[6:0], bit_q};
  assign byte_done = sck_p && (bit_cnt == 3'd7);
  // Frame end is clean only on a byte boundary after at least one data byte.
  assign partial   = !byte_done && ((bit_cnt != 3'd0) || sck_p || !data_seen);
  assign wr_nxt    = '{adrs: ptr, data: byte_nxt};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      ptr        <= '0;
      data_seen  <= 1'b0;
      synth_ctrl <= '0;
      synth_data <= '0;
      reg_adrs   <= '0;
      reg_data   <= '0;
      reg_wr     <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      reg_wr <= 1'b0;
      case (state)
        IDLE: begin
          if (ss_fall_p) begin
            state     <= ADDR;
            bit_cnt   <= '0;
            shreg     <= '0;
            data_seen <= 1'b0;
          end
        end
        ADDR: begin
          if (ss_rise_p) begin
            state     <= IDLE;
            frame_err <= 1'b1;
          end else if (sck_p) begin
            shreg   <= byte_nxt;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              ptr   <= byte_nxt;
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (sck_p) begin
            shreg   <= byte_nxt;
            bit_cnt <= bit_cnt + 3'd1;
          end
          if (byte_done) begin
            reg_adrs  <= wr_nxt.adrs;
            reg_data  <= wr_nxt.data;
            reg_wr    <= 1'b1;
            data_seen <= 1'b1;
            ptr       <= ptr + 8'd1;
            if (wr_nxt.adrs == CTRL_ADRS) synth_ctrl <= wr_nxt.data;
            if (wr_nxt.adrs == DATA_ADRS) synth_data <= wr_nxt.data;
          end
          if (ss_rise_p) begin
            state <= IDLE;
            if (partial) frame_err <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/spi_ctrl_rx.md
# spi_ctrl_rx

Serial control-port receiver for the synthesizer. It accepts write-only register frames from the external microcontroller over the 3-wire sck/sdi/ss_n interface (SPI mode 0, MSB first) and brings them into the clk domain. It holds the control and data bytes that drive the arbiter's `synth_ctrl`/`synth_data` inputs, and it emits a one-cycle write strobe with address and data for any other register consumer.

## Interface
- CTRL_ADRS, 8'h00: register address that loads `synth_ctrl`.
- DATA_ADRS, 8'h01: register address that loads `synth_data`.
- clk  input  1  system clock; all logic runs on its rising edge.
- reset_n  input  1  asynchronous active-low reset.
- sck  input  1  serial clock from the microcontroller, asynchronous to clk; idle low.
- sdi  input  1  serial data, asynchronous; sampled on sck rising edge.
- ss_n  input  1  active-low frame select, asynchronous.
- synth_ctrl  output  8  control register.
- synth_data  output  8  data register.
- reg_adrs  output  8  address of the current write.
- reg_data  output  8  data of the current write.
- reg_wr  output  1  one-clk write strobe qualifying `reg_adrs`/`reg_data`.
- frame_err  output  1  sticky flag: a frame ended on a non-byte boundary.

## Operation
- Clock domains:
  - `sck`, `sdi` and `ss_n` each pass through a 2-flop synchronizer in clk.
  - A third flop on synced `sck` and `ss_n` provides edge detection.
  - The `sdi` path has matched depth, so the sampled bit aligns with the detected sck rise.
- Frame format: ss_n falls, then 8 address bits, then N≥1 data bytes, then ss_n rises. Bits are MSB first.
- Burst addressing: the first data byte goes to the received address. Each following data byte goes to the previous address +1, wrapping 8'hFF to 8'h00.
- FSM states:
  - IDLE: ss_n high. Leave to ADDR on the synced ss_n falling edge; clear the bit counter and shift register.
  - ADDR: shift one bit per sck rise. On the 8th bit, latch the address pointer, go to DATA, clear the bit counter.
  - DATA: shift one bit per sck rise. On the 8th bit, drive the write (below), increment the pointer, clear the counter, stay in DATA.
  - Any state: a synced ss_n rise returns to IDLE. A partial byte is discarded with no write.
- Write action: `reg_adrs` ← pointer, `reg_data` ← assembled byte, `reg_wr` = 1 for exactly one clk.
  - In the same cycle, `synth_ctrl` loads if the pointer equals CTRL_ADRS, and `synth_data` loads if it equals DATA_ADRS.
  - Other addresses update only `reg_adrs`/`reg_data`.
- `frame_err`:
  - Sets when ss_n rises while the bit counter ≠ 0, or while in ADDR (address incomplete or address-only frame).
  - Cleared only by reset.
- Ignored inputs: sck edges while ss_n is high. sdi is don't-care outside sampled edges.

## Timing
- Reset (asynchronous, immediate): `synth_ctrl`=8'h00, `synth_data`=8'h00, `reg_adrs`=8'h00, `reg_data`=8'h00, `reg_wr`=0, `frame_err`=0, FSM=IDLE, synchronizers=0 (ss_n sync flops reset to 1).
- Edge detect latency: a pin-level sck rise is seen as a one-clk internal pulse 3 clk edges later.
- Write latency: `reg_wr` asserts on the clk edge following the internal pulse of the 8th data bit, which is 4 clk after the pin edge. Registers update in that same cycle.
- Input constraint: f_clk ≥ 8 × f_sck. sck high and low times are each ≥ 3 clk. ss_n setup before the first sck rise is ≥ 3 clk. ss_n hold after the last sck rise is ≥ 3 clk.
- Simultaneous events:
  - ss_n rise detected in the same clk as the 8th-bit pulse: the byte completes and writes; no error.
  - ss_n fall detected in the same clk as an sck pulse: that sck pulse is ignored.
- `reg_wr` is never asserted on consecutive clks.
- Reset mid-frame: the FSM returns to IDLE. The frame in progress is lost, even after reset releases, until the next ss_n fall.

## Test plan
- Reset with no frame: all outputs zero; toggle sck with ss_n high → no `reg_wr`, registers stay 8'h00.
- Frame addr 8'h00, data 8'hA5 → one `reg_wr` with `reg_adrs`=00, `reg_data`=A5; `synth_ctrl`=A5, `synth_data` unchanged; `frame_err`=0.
- Burst addr 8'h00, data 8'h3C, 8'hC3 → two strobes (00/3C, 01/C3); `synth_ctrl`=3C, `synth_data`=C3.
- Burst addr 8'hFF, data 11, 22 → strobes FF/11 then 00/22; `synth_ctrl`=22.
- Frame addr 8'h01, then 5 data bits, then ss_n rise → no write, `synth_data` unchanged, `frame_err`=1. Next valid frame 01/7E → `synth_data`=7E, `frame_err` stays 1.
- Assert reset_n=0 after 4 data bits of 00/FF, release, complete the bits → no write. A fresh frame 00/FF → `synth_ctrl`=FF.
